seg7_scan_decoder: RTL

Receive-side decoder for multiplexed 7-segment display lines: samples the segment bus, decimal point and one-hot digit-select lines driven by the display path, converts each settled segment pattern back to a 4-bit digit code, and assembles a full frame of DIGITS digits. It sits on the display-monitor path, used for self-check of the encoder output and for read-back of what the water-detection panel is actually showing. Completed frames are offered on a single-entry valid/ready output.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_pattern_decode.sv | 32 +++
 rtl/seg7_scan_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: digit patterns, special codes
// and the settle-FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [6:0] SEG_BLANK    = 7'h00;
  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } settle_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to digit-code converter; unknown patterns map
// to CODE_INVALID with the invalid flag raised.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg7,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    invalid = 1'b0;
    case (seg7)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code    = CODE_INVALID;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment receive decoder: settles on each one-hot digit select,
// captures the decoded digit, and offers complete frames on a one-entry output.
// Invalid-pattern reporting (err / frame_err) is built only with SEG7_SCAN_ERRCHK_EN.
//
//   state     | meaning
//   ST_IDLE   | dig_sel zero or multi-hot, nothing tracked
//   ST_SETTLE | one-hot value seen, waiting for it to hold SETTLE_CYC cycles
//   ST_HOLD   | digit captured, waiting for dig_sel to change
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SETTLE_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg7,
  input  logic                  dp,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   num_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  err,
  output logic                  ovf
);

  localparam int         IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  logic [3:0] code;
  logic       code_bad;

  seg7_pattern_decode u_decode (
    .seg7    (seg7),
    .code    (code),
    .invalid (code_bad)
  );

  settle_state_e      state;
  logic [DIGITS-1:0]  sel_q;
  logic [3:0]         cnt;
  logic               one_hot;
  logic               new_sel;
  logic               capture;
  logic [IDX_W-1:0]   cap_idx;

  always_comb begin
    one_hot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
    new_sel = one_hot && ((state == ST_IDLE) || (dig_sel != sel_q));
    if (new_sel)
      capture = (SETTLE_CYC == 1);
    else
      capture = one_hot && (state == ST_SETTLE) && (cnt == 4'd1);
  end

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (dig_sel[i]) cap_idx = IDX_W'(i);
  end

  // cnt counts down the remaining settle cycles; terminal count 1 means capture now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel_q <= '0;
      cnt   <= '0;
    end else if (new_sel) begin
      sel_q <= dig_sel;
      cnt   <= SETTLE_LOAD;
      state <= (SETTLE_CYC == 1) ? ST_HOLD : ST_SETTLE;
    end else if (!one_hot) begin
      state <= ST_IDLE;
    end else if (state == ST_SETTLE) begin
      if (cnt == 4'd1)
        state <= ST_HOLD;
      else
        cnt <= cnt - 4'd1;
    end
  end

  logic [4*DIGITS-1:0] slots;
  logic [DIGITS-1:0]   slot_dp;
  logic [DIGITS-1:0]   mask;
  logic [DIGITS-1:0]   mask_nxt;
  logic                frame_done;
  logic                frame_pend;
  logic                load_out;

  always_comb begin
    mask_nxt   = mask | (DIGITS'(1) << cap_idx);
    frame_done = capture && (&mask_nxt);
    load_out   = frame_pend && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots      <= '0;
      slot_dp    <= '0;
      mask       <= '0;
      frame_pend <= 1'b0;
    end else begin
      frame_pend <= frame_done;
      if (capture) begin
        slots[4*int'(cap_idx) +: 4] <= code;
        slot_dp[cap_idx]            <= dp;
        mask                        <= frame_done ? '0 : mask_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_out   <= '0;
      dp_out    <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ovf <= frame_pend && !load_out;
      if (load_out) begin
        num_out   <= slots;
        dp_out    <= slot_dp;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SEG7_SCAN_ERRCHK_EN
  logic [DIGITS-1:0] bad;
  logic [DIGITS-1:0] bad_nxt;
  logic              frame_bad_pend;
  logic              bad_cap_q;

  always_comb begin
    bad_nxt          = bad;
    bad_nxt[cap_idx] = code_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad            <= '0;
      frame_bad_pend <= 1'b0;
      bad_cap_q      <= 1'b0;
      err            <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      bad_cap_q <= capture && code_bad;
      err       <= bad_cap_q;
      if (capture) begin
        bad            <= frame_done ? '0 : bad_nxt;
        frame_bad_pend <= |bad_nxt;
      end
      if (load_out)
        frame_err <= frame_bad_pend;
    end
  end
`else
  assign err       = 1'b0;
  assign frame_err = 1'b0;
`endif

endmodule
